// File: rtl/cic_decimator_mc_if.sv
// Stream bundle for cic_decimator_mc: parallel multi-channel input samples and the
// serialized, ready/valid decimated output.
interface cic_decimator_mc_if #(
    parameter int unsigned IN_W  = 5,
    parameter int unsigned NCH   = 2,
    parameter int unsigned OUT_W = 10,
    parameter int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic                in_valid;
    logic [NCH*IN_W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_data;
    logic [CH_W-1:0]     out_ch;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_ch
    );
endinterface

// File: rtl/cic_decimator_mc.sv
// NCH-channel, N-stage CIC decimator with run-time ratio 2^L, rounding/saturating output
// scaler and a one-frame buffer serialized onto a ready/valid stream.
module cic_decimator_mc #(
    parameter int unsigned IN_W      = 5,
    parameter int unsigned N         = 5,
    parameter int unsigned LOG2R_MAX = 4,
    parameter int unsigned NCH       = 2,
    parameter int unsigned OUT_W     = 10,
    localparam int unsigned ACC_W    = IN_W + N * LOG2R_MAX,
    localparam int unsigned L_W      = $clog2(LOG2R_MAX + 1),
    localparam int unsigned CH_W     = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned PH_W     = (LOG2R_MAX > 0) ? LOG2R_MAX : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [L_W-1:0]    cfg_log2r_i,
    cic_decimator_mc_if.slave bus,
    output logic              ovf_o
);

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    function automatic logic [L_W-1:0] clamp_l(input logic [L_W-1:0] l);
        if (l == '0) begin
            return L_W'(1);
        end else if (int'(l) > int'(LOG2R_MAX)) begin
            return L_W'(LOG2R_MAX);
        end else begin
            return l;
        end
    endfunction

    logic                    en_q, run_q;
    logic                    rise, run, accept, strobe;
    logic [L_W-1:0]          l_act_q, l_act_d;
    logic [PH_W-1:0]         phase_q, phase_d, ratio_m1;
    logic                    strobe_q;

    logic signed [ACC_W-1:0] integ_q [NCH][N];
    logic signed [ACC_W-1:0] integ_d [NCH][N];
    logic signed [ACC_W-1:0] samp_q  [NCH];
    logic signed [ACC_W-1:0] samp_d  [NCH];
    logic signed [ACC_W-1:0] dly_q   [NCH][N];
    logic signed [ACC_W-1:0] dly_d   [NCH][N];
    logic signed [ACC_W-1:0] comb_c  [NCH][N+1];
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W:0]   rnd;
    logic signed [OUT_W-1:0] scaled  [NCH];
    int                      shift;

    logic signed [OUT_W-1:0] buf_q   [NCH];
    logic signed [OUT_W-1:0] buf_d   [NCH];
    logic                    full_q, full_d;
    logic [CH_W-1:0]         rd_ch_q, rd_ch_d;
    logic                    ovf_q, ovf_d;
    logic                    hs, last_hs;

    // run only goes high on an observed en rise; en_q resets high so a held-high en after
    // reset release does not count as a rise.
    always_comb begin
        rise     = en_i && !en_q;
        run      = en_i && (run_q || rise);
        l_act_d  = rise ? clamp_l(cfg_log2r_i) : l_act_q;
        ratio_m1 = PH_W'((32'd1 << l_act_q) - 32'd1);
        accept   = run && bus.in_valid;
        strobe   = accept && (phase_q == ratio_m1);
        phase_d  = phase_q;
        if (!run) begin
            phase_d = '0;
        end else if (accept) begin
            phase_d = strobe ? '0 : phase_q + PH_W'(1);
        end
    end

    always_comb begin
        integ_d = integ_q;
        samp_d  = samp_q;
        dly_d   = dly_q;
        x_ext   = '0;
        if (!run) begin
            integ_d = '{default: '0};
            samp_d  = '{default: '0};
            dly_d   = '{default: '0};
        end else begin
            if (accept) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    x_ext = {{(ACC_W - IN_W){bus.in_data[ch*IN_W + IN_W - 1]}},
                             bus.in_data[ch*IN_W +: IN_W]};
                    integ_d[ch][0] = integ_q[ch][0] + x_ext;
                    for (int k = 1; k < N; k++) begin
                        integ_d[ch][k] = integ_q[ch][k] + integ_q[ch][k-1];
                    end
                    if (strobe) begin
                        samp_d[ch] = integ_q[ch][N-1];
                    end
                end
            end
            if (strobe_q) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    for (int k = 0; k < N; k++) begin
                        dly_d[ch][k] = comb_c[ch][k];
                    end
                end
            end
        end
    end

    // Comb cascade and scaler; rounding is done one bit wider so c + 2^(S-1) cannot wrap.
    always_comb begin
        shift = int'(IN_W) + int'(N) * int'(l_act_q) - int'(OUT_W);
        rnd   = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            comb_c[ch][0] = samp_q[ch];
            for (int k = 0; k < N; k++) begin
                comb_c[ch][k+1] = comb_c[ch][k] - dly_q[ch][k];
            end
            rnd = {comb_c[ch][N][ACC_W-1], comb_c[ch][N]};
            if (shift > 0) begin
                rnd = rnd + ((ACC_W + 1)'(1) << (shift - 1));
            end
            rnd = rnd >>> shift;
            if (rnd > SAT_MAX) begin
                scaled[ch] = SAT_MAX[OUT_W-1:0];
            end else if (rnd < SAT_MIN) begin
                scaled[ch] = SAT_MIN[OUT_W-1:0];
            end else begin
                scaled[ch] = rnd[OUT_W-1:0];
            end
        end
    end

    // A frame landing on the same edge as the final handshake of the previous one is
    // accepted, which keeps a 2:1 ratio gap-free with out_ready held high.
    always_comb begin
        hs      = full_q && bus.out_ready;
        last_hs = hs && (rd_ch_q == CH_W'(NCH - 1));
        full_d  = full_q;
        rd_ch_d = rd_ch_q;
        buf_d   = buf_q;
        ovf_d   = ovf_q;
        if (!run) begin
            full_d  = 1'b0;
            rd_ch_d = '0;
            buf_d   = '{default: '0};
            ovf_d   = 1'b0;
        end else begin
            if (hs) begin
                if (last_hs) begin
                    full_d  = 1'b0;
                    rd_ch_d = '0;
                end else begin
                    rd_ch_d = rd_ch_q + CH_W'(1);
                end
            end
            if (strobe_q) begin
                if (!full_q || last_hs) begin
                    full_d  = 1'b1;
                    rd_ch_d = '0;
                    buf_d   = scaled;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b1;
            run_q    <= 1'b0;
            l_act_q  <= L_W'(1);
            phase_q  <= '0;
            strobe_q <= 1'b0;
            integ_q  <= '{default: '0};
            samp_q   <= '{default: '0};
            dly_q    <= '{default: '0};
            buf_q    <= '{default: '0};
            full_q   <= 1'b0;
            rd_ch_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            en_q     <= en_i;
            run_q    <= run;
            l_act_q  <= l_act_d;
            phase_q  <= phase_d;
            strobe_q <= strobe;
            integ_q  <= integ_d;
            samp_q   <= samp_d;
            dly_q    <= dly_d;
            buf_q    <= buf_d;
            full_q   <= full_d;
            rd_ch_q  <= rd_ch_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.out_valid = full_q;
    assign bus.out_data  = buf_q[rd_ch_q];
    assign bus.out_ch    = rd_ch_q;
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Bench for cic_decimator_mc: expected frames come from the CIC impulse response applied
// to the recorded input history, and a frame-level buffer model predicts the stream.
module tb_cic_decimator_mc;
    localparam int unsigned IN_W      = 5;
    localparam int unsigned N         = 5;
    localparam int unsigned LOG2R_MAX = 4;
    localparam int unsigned NCH       = 2;
    localparam int unsigned OUT_W     = 10;
    localparam int unsigned L_W       = $clog2(LOG2R_MAX + 1);
    localparam int HMAX   = 4096;
    localparam int HLEN   = 128;
    localparam int YMAX   = (1 << (OUT_W - 1)) - 1;
    localparam int YMIN   = -(1 << (OUT_W - 1));
    localparam int DC_POS = 15 * (1 << (OUT_W - IN_W));
    localparam int DC_NEG = -16 * (1 << (OUT_W - IN_W));

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [L_W-1:0] cfg;
    logic           ovf;
    int             checks = 0;
    int             failures = 0;

    // reference model state
    int  hist [NCH][HMAX];
    int  n_acc;
    int  l_act;
    bit  en_prev, run_prev;
    bit  m_valid, m_ovf, wr_due;
    int  m_ch;
    int  m_frame [NCH];
    int  pend [NCH];

    cic_decimator_mc_if #(.IN_W(IN_W), .NCH(NCH), .OUT_W(OUT_W)) bus ();

    cic_decimator_mc #(
        .IN_W(IN_W), .N(N), .LOG2R_MAX(LOG2R_MAX), .NCH(NCH), .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en_i(en),
        .cfg_log2r_i(cfg),
        .bus(bus),
        .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp_cfg(input int c);
        if (c == 0) return 1;
        if (c > int'(LOG2R_MAX)) return int'(LOG2R_MAX);
        return c;
    endfunction

    // Output of frame ending at input index n: ((1-z^-R)/(1-z^-1))^N, delayed N samples.
    function automatic int ref_out(input int ch, input int n, input int l);
        longint h [HLEN];
        longint t [HLEN];
        longint acc;
        int     len, r, s;
        r = 1 << l;
        h = '{default: 0};
        h[0] = 1;
        len = 1;
        for (int st = 0; st < int'(N); st++) begin
            t = '{default: 0};
            for (int i = 0; i < len; i++)
                for (int j = 0; j < r; j++) t[i+j] += h[i];
            len += r - 1;
            h = t;
        end
        acc = 0;
        for (int i = 0; i < len; i++) begin
            int j;
            j = n - int'(N) - i;
            if (j >= 0) acc += h[i] * hist[ch][j];
        end
        s = int'(IN_W) + int'(N) * l - int'(OUT_W);
        if (s > 0) acc = (acc + (longint'(1) << (s - 1))) >>> s;
        if (acc > YMAX) acc = YMAX;
        if (acc < YMIN) acc = YMIN;
        return int'(acc);
    endfunction

    task automatic model_clear();
        m_valid = 0;
        m_ch    = 0;
        m_ovf   = 0;
        wr_due  = 0;
        n_acc   = 0;
    endtask

    task automatic model_reset();
        en_prev  = 1;
        run_prev = 0;
        l_act    = 1;
        model_clear();
    endtask

    // Compare this cycle's outputs, then advance the model across the coming edge.
    task automatic model_cycle();
        bit rise, run, hs, last, was_valid;
        int r;
        check_eq("out_valid", bus.out_valid, m_valid);
        if (m_valid) begin
            check_eq("out_ch", bus.out_ch, m_ch);
            check_eq("out_data", $signed(bus.out_data), m_frame[m_ch]);
        end
        check_eq("ovf", ovf, m_ovf);
        rise = en && !en_prev;
        run  = en && (run_prev || rise);
        if (!run) begin
            model_clear();
        end else begin
            if (rise) l_act = clamp_cfg(int'(cfg));
            r         = 1 << l_act;
            hs        = m_valid && bus.out_ready;
            last      = hs && (m_ch == int'(NCH) - 1);
            was_valid = m_valid;
            if (hs) begin
                if (last) begin
                    m_valid = 0;
                    m_ch    = 0;
                end else begin
                    m_ch++;
                end
            end
            if (wr_due) begin
                if (!was_valid || last) begin
                    m_valid = 1;
                    m_ch    = 0;
                    m_frame = pend;
                end else begin
                    m_ovf = 1;
                end
            end
            wr_due = 0;
            if (bus.in_valid && n_acc < HMAX) begin
                for (int k = 0; k < int'(NCH); k++)
                    hist[k][n_acc] = int'($signed(bus.in_data[k*IN_W +: IN_W]));
                if (n_acc % r == r - 1) begin
                    for (int k = 0; k < int'(NCH); k++) pend[k] = ref_out(k, n_acc, l_act);
                    wr_due = 1;
                end
                n_acc++;
            end
        end
        en_prev  = en;
        run_prev = run;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_data(input int mode, input int c);
        for (int k = 0; k < int'(NCH); k++) begin
            int v;
            case (mode)
                0:       v = int'($urandom_range(31)) - 16;
                1:       v = (k == 0) ? 15 : -16;
                2:       v = (k == 0 && c == 0) ? 1 : 0;
                default: v = ((c / (3 + k)) % 2 == 0) ? 15 : 0;
            endcase
            bus.in_data[k*IN_W +: IN_W] = IN_W'(v);
        end
    endtask

    task automatic run_cycles(input int cycles, input int mode, input int vprob,
                              input int rprob);
        for (int c = 0; c < cycles; c++) begin
            bus.in_valid  = (int'($urandom_range(99)) < vprob);
            bus.out_ready = (int'($urandom_range(99)) < rprob);
            drive_data(mode, c);
            step();
        end
    endtask

    task automatic start(input int l);
        bus.in_valid = 1'b0;
        en = 1'b0;
        step();
        cfg = L_W'(l);
        en  = 1'b1;
    endtask

    // Wait for the next ch0 beat under DC drive and check both channels against x*2^(OUT_W-IN_W).
    task automatic dc_probe(input string tag);
        bit done;
        done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            drive_data(1, c);
            @(negedge clk);
            if (bus.out_valid && bus.out_ch == 0) begin
                check_eq({tag, "_ch0"}, $signed(bus.out_data), DC_POS);
                model_cycle();
                @(posedge clk);
                #1;
                @(negedge clk);
                check_eq({tag, "_ch1_valid"}, bus.out_valid, 1);
                check_eq({tag, "_ch1"}, $signed(bus.out_data), DC_NEG);
                done = 1;
            end
            model_cycle();
            @(posedge clk);
            #1;
        end
        if (!done) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        en            = 1'b0;
        cfg           = L_W'(1);
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        model_reset();
        #1;
        check_eq("reset_out_valid", bus.out_valid, 0);
        check_eq("reset_out_data", $signed(bus.out_data), 0);
        check_eq("reset_out_ch", bus.out_ch, 0);
        check_eq("reset_ovf", ovf, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // DC at 2:1 and 16:1
        start(1);
        run_cycles(60, 1, 100, 100);
        dc_probe("dc_l1");
        check_eq("dc_l1_no_ovf", ovf, 0);
        start(4);
        run_cycles(16 * 8, 1, 100, 100);
        dc_probe("dc_l4");
        check_eq("dc_l4_no_ovf", ovf, 0);

        // impulse on ch0 at 4:1
        start(2);
        run_cycles(4 * 12, 2, 100, 100);

        // backpressure: first frame held, later frames dropped
        start(1);
        run_cycles(10, 0, 100, 100);
        run_cycles(12, 0, 100, 0);
        check_eq("bp_ovf", ovf, 1);
        run_cycles(20, 0, 100, 100);

        // cfg change while running is ignored; takes effect after en toggles
        start(1);
        run_cycles(20, 0, 100, 100);
        cfg = L_W'(3);
        run_cycles(30, 0, 100, 100);
        start(3);
        run_cycles(80, 0, 100, 100);

        // random traffic, including illegal exponents
        start(0);
        run_cycles(200, 0, 70, 60);
        start(2);
        run_cycles(200, 0, 80, 50);
        start(5);
        run_cycles(200, 0, 90, 70);
        start(7);
        run_cycles(200, 0, 60, 80);

        // non-negative alternating drive at 16:1
        start(4);
        run_cycles(200, 3, 100, 100);

        // asynchronous reset mid-frame while a stalled frame is presented
        start(1);
        run_cycles(8, 0, 100, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_out_valid", bus.out_valid, 0);
        check_eq("rst_mid_out_data", $signed(bus.out_data), 0);
        check_eq("rst_mid_out_ch", bus.out_ch, 0);
        check_eq("rst_mid_ovf", ovf, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycles(20, 0, 100, 100);
        start(1);
        run_cycles(40, 0, 100, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
